// File: rtl/arb_pkg.sv
// arb_pkg: shared types, widths and helpers for the parametrised arbiter.
package arb_pkg;
    typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e;
    localparam int ARB_HOLD_W = 8;
    function automatic int onehot_to_idx(input logic [15:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 16; i++)
            if (v[i]) idx = i;
        return idx;
    endfunction
endpackage

// File: rtl/arb_prio_sel.sv
// arb_prio_sel: masked priority encoder that searches upward from start, wrapping.
module arb_prio_sel #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt
);
    logic [N-1:0] elig, rot, first;
    assign elig  = req & mask;
    // rotate so start sits at bit 0, isolate the lowest set bit, rotate back
    assign rot   = N'({elig, elig} >> start);
    assign first = rot & (-rot);
    assign gnt   = N'(({first, first} << start) >> N);
endmodule

// File: rtl/arb_rr_param.sv
// arb_rr_param: N-requester arbiter, round-robin or fixed priority, with grant
// hold and an optional burst limit that forces rotation when others wait.
module arb_rr_param import arb_pkg::*; #(
    parameter int        N_REQ    = 4,
    parameter arb_mode_e MODE     = ARB_RR,
    parameter int        MAX_HOLD = 8,
    localparam int       IDX_W    = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      request,
    output logic [N_REQ-1:0]      grant,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  grant_valid,
    output logic [ARB_HOLD_W-1:0] hold_cnt
);
    logic [N_REQ-1:0]      grant_q, grant_d, sel;
    logic [IDX_W-1:0]      ptr_q, ptr_d, start;
    logic [ARB_HOLD_W-1:0] hold_q, hold_d;
    logic                  holder_req, others_req, force_rot, keep, change;

    assign holder_req = |(grant_q & request);
    assign others_req = |(request & ~grant_q);
    assign force_rot  = (MAX_HOLD > 0) && (int'(hold_q) == MAX_HOLD - 1) && holder_req && others_req;
    assign keep       = holder_req && !force_rot;
    // ptr_q holds the next search start, so reset naturally begins at index 0
    assign start      = (MODE == ARB_FIXED) ? '0 : ptr_q;

    arb_prio_sel #(.N(N_REQ), .IW(IDX_W)) u_sel (
        .req  (request),
        .mask (~grant_q),
        .start(start),
        .gnt  (sel)
    );

    always_comb begin
        grant_d = keep ? grant_q : sel;
        change  = grant_d != grant_q;
        hold_d  = (change || grant_d == '0) ? '0 : (&hold_q ? hold_q : hold_q + ARB_HOLD_W'(1));
        ptr_d   = (change && |grant_d) ? IDX_W'((onehot_to_idx(16'(grant_d)) + 1) % N_REQ) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_idx   = IDX_W'(onehot_to_idx(16'(grant_q)));
    assign hold_cnt    = hold_q;

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
    a_req_ok: assert property (@(posedge clk) disable iff (!rst_n) (grant_d & ~request) == '0);
endmodule

// File: tb/tb_arb_rr_param.sv
// tb_arb_rr_param: scoreboard bench over three arbiter configurations
// (RR unlimited, RR with MAX_HOLD=4, fixed priority).
module tb_arb_rr_param;
    import arb_pkg::*;

    typedef struct {
        int         d;
        logic [3:0] g;
        int         h;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req  [3];
    logic [3:0] gnt  [3];
    logic [1:0] gidx [3];
    logic       gv   [3];
    logic [7:0] hc   [3];
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    arb_rr_param #(.N_REQ(4), .MODE(ARB_RR), .MAX_HOLD(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .request(req[0]), .grant(gnt[0]),
        .grant_idx(gidx[0]), .grant_valid(gv[0]), .hold_cnt(hc[0]));
    arb_rr_param #(.N_REQ(4), .MODE(ARB_RR), .MAX_HOLD(4)) u_fr (
        .clk(clk), .rst_n(rst_n), .request(req[1]), .grant(gnt[1]),
        .grant_idx(gidx[1]), .grant_valid(gv[1]), .hold_cnt(hc[1]));
    arb_rr_param #(.N_REQ(4), .MODE(ARB_FIXED), .MAX_HOLD(0)) u_fx (
        .clk(clk), .rst_n(rst_n), .request(req[2]), .grant(gnt[2]),
        .grant_idx(gidx[2]), .grant_valid(gv[2]), .hold_cnt(hc[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] g);
        for (int i = 0; i < 4; i++)
            if (g[i]) return i;
        return 0;
    endfunction

    task automatic push(input int d, input logic [3:0] g, input int h, input string tag);
        exp_t e;
        e.d = d; e.g = g; e.h = h; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".grant"}, 32'(gnt[e.d]), 32'(e.g));
            chk({e.tag, ".idx"},   32'(gidx[e.d]), 32'(idx_of(e.g)));
            chk({e.tag, ".valid"}, 32'(gv[e.d]), 32'(|e.g));
            chk({e.tag, ".hold"},  32'(hc[e.d]), 32'(e.h));
        end
    endtask

    task automatic step(input int d, input logic [3:0] r, input logic [3:0] g, input int h, input string tag);
        req[d] = r;
        push(d, g, h, tag);
        tick();
    endtask

    initial begin
        req[0] = 4'hf; req[1] = 4'hf; req[2] = 4'hf;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst.grant%0d", d), 32'(gnt[d]), 32'd0);
            chk($sformatf("rst.valid%0d", d), 32'(gv[d]), 32'd0);
            chk($sformatf("rst.hold%0d", d), 32'(hc[d]), 32'd0);
        end
        req[1] = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        push(2, 4'b0001, 0, "fx_first");
        step(0, 4'b1111, 4'b0001, 0, "rr_first");
        req[2] = 4'h0;
        push(2, 4'b0000, 0, "fx_idle");
        step(0, 4'b1110, 4'b0010, 0, "rr_to1");
        step(0, 4'b1101, 4'b0100, 0, "rr_to2");
        step(0, 4'b1011, 4'b1000, 0, "rr_to3");
        step(0, 4'b0111, 4'b0001, 0, "rr_wrap");
        step(0, 4'b1111, 4'b0001, 1, "rr_hold1");
        step(0, 4'b1111, 4'b0001, 2, "rr_hold2");
        step(0, 4'b0010, 4'b0010, 0, "rr_mv1");
        step(0, 4'b1001, 4'b1000, 0, "rr_simul");
        step(0, 4'b0000, 4'b0000, 0, "rr_idle0");
        step(0, 4'b0000, 4'b0000, 0, "rr_idle1");
        step(0, 4'b0110, 4'b0010, 0, "rr_ptr_kept");
        step(0, 4'b0100, 4'b0100, 0, "rr_to2b");
        for (int i = 0; i < 4; i++) step(1, 4'b0011, 4'b0001, i, "fr_a");
        for (int i = 0; i < 4; i++) step(1, 4'b0011, 4'b0010, i, "fr_b");
        step(1, 4'b0011, 4'b0001, 0, "fr_back");
        for (int i = 1; i <= 5; i++) step(1, 4'b0001, 4'b0001, i, "fr_solo");
        step(2, 4'b1100, 4'b0100, 0, "fx_2");
        step(2, 4'b1010, 4'b0010, 0, "fx_1");
        step(2, 4'b1010, 4'b0010, 1, "fx_starve1");
        step(2, 4'b1110, 4'b0010, 2, "fx_starve2");
        step(2, 4'b1001, 4'b0001, 0, "fx_simul");
        step(2, 4'b1000, 4'b1000, 0, "fx_3");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.grant", 32'(gnt[0]), 32'd0);
        chk("midrst.valid", 32'(gv[0]), 32'd0);
        chk("midrst.idx",   32'(gidx[0]), 32'd0);
        chk("midrst.hold",  32'(hc[0]), 32'd0);
        req[0] = 4'hf;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 4'b1111, 4'b0001, 0, "rr_restart");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/arb_rr_param.md
Name: arb_rr_param

Overview:
- Parametrised N-requester arbiter; successor to the 2-requester arbiter that sits behind the arb_if DUT modport.
- Selectable round-robin or fixed-priority policy.
- Grant is held while the requester keeps its request asserted, with an optional burst limit that forces rotation.
- Registered one-hot grant plus encoded index; drops into the existing test/monitor environment when N_REQ=2.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- MODE, ARB_RR, policy: ARB_RR (round-robin) or ARB_FIXED (index 0 highest priority).
- MAX_HOLD, 8, max consecutive grant cycles while others wait; 0 = unlimited (1..255 otherwise).
- IDX_W, $clog2(N_REQ), width of grant_idx (derived, not overridden).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- request, input, N_REQ, per-requester request level.
- grant, output, N_REQ, registered one-hot (or zero) grant.
- grant_idx, output, IDX_W, index of granted requester; 0 when grant_valid=0.
- grant_valid, output, 1, high when any grant bit set.
- hold_cnt, output, 8, cycles current grant has been held (debug/monitor).

Behaviour:
- Reset values (rst_n low, asynchronous): grant=0, grant_valid=0, grant_idx=0, hold_cnt=0, RR pointer=0.
- Grant outputs drop immediately on rst_n assertion, including mid-grant.
- First edge after rst_n release evaluates normally.
- Decision timing: every posedge samples request and the current grant; the new grant is registered on that edge.
  - Request set before edge k, with no grant active → grant visible after edge k (1-cycle latency).
- Holding: if the current holder's request bit is still 1 and no forced rotation applies → grant unchanged; hold_cnt increments, saturating at 255.
- Release: holder's request = 0 at an edge → grant moves that same edge to the next winner per policy, or to 0 if no requests. No idle bubble.
- Forced rotation (MAX_HOLD>0):
  - Trigger: hold_cnt == MAX_HOLD-1, holder still requesting, and any other request bit = 1.
  - Result: grant moves to the next winner with the holder excluded.
  - If no other requester exists → holder keeps grant; hold_cnt keeps counting.
- hold_cnt: resets to 0 on every grant change (including to idle); counts 0,1,2,... while the same grant is held.
- ARB_RR policy:
  - Search starts at (last granted index + 1) mod N_REQ, wrapping.
  - RR pointer updates only when a new grant is issued; idle cycles leave it unchanged.
  - After reset, search starts at index 0.
- ARB_FIXED policy: lowest-index eligible request wins. On forced rotation, the lowest-index requester other than the holder wins.
- Invariant: at most one grant bit set every cycle; assertion required in RTL.
- Invariant: a grant bit is never set for a requester whose request was 0 at the deciding edge.
- Simultaneous holder release and new requests at one edge: the winner is chosen among the new requests, holder excluded.
- X on request: no requirement; bench drives known values only.

Decomposition:
- Package arb_pkg:
  - typedef enum arb_mode_e {ARB_RR, ARB_FIXED};
  - constant ARB_HOLD_W = 8;
  - function onehot_to_idx.
- Sub-module arb_prio_sel:
  - Combinational masked priority encoder: inputs req, mask, start index; output one-hot winner.
  - Instantiated once; arb_rr_param supplies the exclusion mask and the rotation start.
- Interface:
  - arb_if generalised with N_REQ parameter and rst_n.
  - Modports DUT/TEST/MON/TESTCB keep their roles; clocking block drives request and samples grant.

Test Plan:
- Reset check: rst_n low, request=4'b1111 → grant=0, grant_valid=0, hold_cnt=0. Release at edge 0 → grant=4'b0001, grant_idx=0 after edge 1.
- Round-robin, MAX_HOLD=0: request=4'b1111 constant; each holder drops request for one cycle once granted → grant sequence 0001,0010,0100,1000,0001. Verify wrap from index 3 to 0.
- Forced rotation, MAX_HOLD=4: request=4'b0011 held → grant 0001 for 4 cycles (hold_cnt 0..3), then 0010 for 4 cycles, then 0001. With request=4'b0001 only → grant stays 0001 and hold_cnt counts past 3.
- Fixed priority, MODE=ARB_FIXED, MAX_HOLD=0: request=4'b1100 → grant 0100. Then request=4'b1110 with bit2 dropped → grant 0010; bit 3 starves until bits 1 and 2 are clear.
- Simultaneous release and new request: holder 0010 drops while request becomes 4'b1001 at the same edge → next grant 0100? no: 1000 in RR (pointer after 1), 0001 in FIXED. No idle cycle in either mode.
- Mid-operation reset: assert rst_n low between edges while grant=0100 → grant=0 immediately (before next edge). After release, RR restarts from index 0.
